fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 0: first word address fetched after reset.
REQ-002 Parameter ROM_DEPTH, default 1024: number of words in the instruction ROM; any address >= ROM_DEPTH is out of range.
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 run  in  1  level; 1 permits fetching, 0 pauses issue.
REQ-006 rom_addr  out  32  word address presented to the ROM; equals internal pc_issue.
REQ-007 rom_instr  in  32  ROM output; holds rom[addr] for the address presented in the previous cycle.
REQ-008 inst_valid  out  1  inst_out and inst_pc hold a valid instruction.
REQ-009 inst_ready  in  1  decode accepts; a transfer occurs when inst_valid and inst_ready are both 1 at a rising edge.
REQ-010 inst_out  out  32  instruction at the head of the output queue.
REQ-011 inst_pc  out  32  word address of inst_out.
REQ-012 redirect  in  1  one-cycle pulse; branch or jump taken.
REQ-013 redirect_pc  in  32  target word address, sampled when redirect=1.
REQ-014 halted  out  1  1 while in HALT.

Function
REQ-015 States: IDLE, FETCH, HALT; IDLE->FETCH when run=1; FETCH->IDLE when run=0; any state->HALT on the stop conditions of REQ-021.
REQ-016 Issue: in FETCH, when occupancy_next < CAP, a rising edge launches a fetch of pc_issue; inflight<=1, inflight_pc<=pc_issue, pc_issue<=pc_issue+1.
REQ-017 occupancy_next = queue count + inflight - (1 if a transfer occurs this edge); CAP is defined in Configuration.
REQ-018 Capture: when inflight=1 and no redirect, rom_instr and inflight_pc are written to the queue tail on the following edge; no instruction is dropped or duplicated.
REQ-019 Output: the queue is FIFO; inst_out and inst_pc come from the head; inst_valid = (count != 0); outputs stay stable while inst_valid=1 and inst_ready=0.
REQ-020 Redirect: on an edge with redirect=1, the queue is flushed, inflight is cleared and not captured, pc_issue<=redirect_pc, and no issue takes place that edge; the target issues on the next edge if it is in range.
REQ-021 HALT: entered when pc_issue >= ROM_DEPTH would be issued, or when redirect_pc >= ROM_DEPTH; queued and in-flight words still drain unless flushed; in HALT, rom_addr holds and there are no issues; HALT is left only by reset.
REQ-022 A transfer and a redirect on the same edge: the transfer counts as accepted, then the flush applies.
REQ-023 run=0: no new issue; an in-flight word is still captured; queued words still drain.
REQ-024 Address arithmetic is 32-bit unsigned; wrap past 0xFFFFFFFF cannot occur because of REQ-021.

Reset
REQ-025 When reset=1: state=IDLE, pc_issue=RESET_PC, inflight=0, queue count=0, inst_valid=0, halted=0, inst_out=0, inst_pc=0; this takes effect immediately, and mid-operation words are discarded.
REQ-026 After reset is released, the first issue occurs on the first edge with run=1 (IDLE->FETCH and issue on the same edge).

Configuration
REQ-027 Macro FETCH_CTRL_QUEUE2_EN defined: CAP=2 (2-entry queue); with inst_ready held at 1, the block sustains one instruction per cycle.
REQ-028 Macro FETCH_CTRL_QUEUE2_EN undefined: CAP=1 (single output register); with inst_ready held at 1, throughput is one instruction per 2 cycles.

Verification
REQ-029 Reset, run=1, inst_ready=1, QUEUE2 on -> inst_valid first high 2 edges after run, with inst_pc=0,1,2,3 on consecutive cycles and inst_out=rom[0..3].
REQ-030 Same stimulus, QUEUE2 off -> inst_pc=0,1,2 on every second cycle, and inst_valid toggles 1,0,1,0.
REQ-031 inst_ready=0 for 5 cycles with the queue full -> inst_out stable, rom_addr constant; after release, the sequence continues with no gap or duplicate.
REQ-032 redirect=1, redirect_pc=8 while inst_pc=3 is being transferred -> pc 3 is accepted, the next valid inst_pc=8 appears 2 edges later, and no pc 4/5 is ever output.
REQ-033 ROM_DEPTH=4, free run -> pc 0..3 are output, then halted=1, with no fetch of address 4; redirect_pc=1024 with ROM_DEPTH=1024 -> HALT on that edge.
REQ-034 reset asserted mid-stream with inst_valid=1 -> inst_valid=0 immediately; after release and run=1, inst_pc restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues ROM word addresses and queues returned words for decode.
// Define FETCH_CTRL_QUEUE2_EN for a 2-entry output queue (1 instr/cycle); default is a single register.
module fetch_ctrl #(
   parameter int unsigned RESET_PC  = 0,
   parameter int unsigned ROM_DEPTH = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        run,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_instr,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        halted
);

`ifdef FETCH_CTRL_QUEUE2_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_issue_q, pc_issue_d;
   logic [31:0] inflight_pc_q, inflight_pc_d;
   logic        inflight_q, inflight_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] q_instr_q [CAP];
   logic [31:0] q_instr_d [CAP];
   logic [31:0] q_pc_q [CAP];
   logic [31:0] q_pc_d [CAP];

   logic        transfer;
   logic [2:0]  occ_next;
   logic        can_issue;
   logic        halt_issue;
   logic        halt_redirect;
   logic        issue;

   assign rom_addr   = pc_issue_q;
   assign inst_valid = (count_q != 2'd0);
   assign inst_out   = inst_valid ? q_instr_q[0] : 32'd0;
   assign inst_pc    = inst_valid ? q_pc_q[0] : 32'd0;
   assign halted     = (state_q == HALT);

   // Issue only when the word can never overflow the queue once it returns.
   always_comb begin
      transfer      = inst_valid & inst_ready;
      occ_next      = 3'(count_q) + 3'(inflight_q) - 3'(transfer);
      can_issue     = (state_q != HALT) && run && !redirect && (occ_next < 3'(CAP));
      halt_issue    = can_issue && (pc_issue_q >= ROM_DEPTH);
      issue         = can_issue && !halt_issue;
      halt_redirect = (state_q != HALT) && redirect && (redirect_pc >= ROM_DEPTH);
   end

   always_comb begin
      state_d       = state_q;
      pc_issue_d    = pc_issue_q;
      inflight_d    = issue;
      inflight_pc_d = issue ? pc_issue_q : inflight_pc_q;
      count_d       = count_q;
      q_instr_d     = q_instr_q;
      q_pc_d        = q_pc_q;

      case (state_q)
         IDLE:    if (run) state_d = FETCH;
         FETCH:   if (!run) state_d = IDLE;
         default: state_d = HALT;
      endcase
      if (halt_issue || halt_redirect) begin
         state_d = HALT;
      end

      if (redirect && (state_q != HALT)) begin
         pc_issue_d = redirect_pc;
      end else if (issue) begin
         pc_issue_d = pc_issue_q + 32'd1;
      end

      // Pop before push so an accepted head and a returning word can share one edge.
      if (transfer) begin
         for (int i = 0; i < CAP - 1; i++) begin
            q_instr_d[i] = q_instr_q[i + 1];
            q_pc_d[i]    = q_pc_q[i + 1];
         end
         count_d = count_q - 2'd1;
      end

      if (redirect) begin
         count_d = 2'd0;
      end else if (inflight_q && (count_d < 2'(CAP))) begin
         for (int i = 0; i < CAP; i++) begin
            if (i == int'(count_d)) begin
               q_instr_d[i] = rom_instr;
               q_pc_d[i]    = inflight_pc_q;
            end
         end
         count_d = count_d + 2'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         pc_issue_q    <= 32'(RESET_PC);
         inflight_q    <= 1'b0;
         inflight_pc_q <= 32'd0;
         count_q       <= 2'd0;
         for (int i = 0; i < CAP; i++) begin
            q_instr_q[i] <= 32'd0;
            q_pc_q[i]    <= 32'd0;
         end
      end else begin
         state_q       <= state_d;
         pc_issue_q    <= pc_issue_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         count_q       <= count_d;
         q_instr_q     <= q_instr_d;
         q_pc_q        <= q_pc_d;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, corner sequences and random traffic
// compared against a queue-based reference model.
module tb_fetch_ctrl;

   localparam int          DEPTH = 64;
   localparam logic [31:0] RPC   = 32'd0;
`ifdef FETCH_CTRL_QUEUE2_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif
   localparam int M_IDLE  = 0;
   localparam int M_FETCH = 1;
   localparam int M_HALT  = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        run;
   logic        instReady;
   logic        redirect;
   logic [31:0] redirectPc;
   logic [31:0] romAddr;
   logic [31:0] romInstr;
   logic [31:0] instOut;
   logic [31:0] instPc;
   logic        instValid;
   logic        halted;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int          mState;
   logic [31:0] mPc;
   bit          mInflight;
   logic [31:0] mIpc;
   logic [31:0] mq[$];
   logic [31:0] dutAcc[$];

   typedef struct {
      logic        run;
      logic        ready;
      logic        redir;
      logic [31:0] rpc;
      logic        expValid;
      logic [31:0] expPc;
   } vec_t;
   vec_t vecs[$];

   always #5 clock = ~clock;

   fetch_ctrl #(.RESET_PC(RPC), .ROM_DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .run(run), .rom_addr(romAddr), .rom_instr(romInstr),
      .inst_valid(instValid), .inst_ready(instReady), .inst_out(instOut), .inst_pc(instPc),
      .redirect(redirect), .redirect_pc(redirectPc), .halted(halted)
   );

   function automatic logic [31:0] romWord(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   // Synchronous ROM: data for the previous cycle's address
   always @(posedge clock) romInstr <= romWord(romAddr);

   function automatic void addVec(input logic r, input logic rd, input logic rdir,
                                  input logic [31:0] rpc, input logic ev, input logic [31:0] epc);
      vec_t v;
      v.run = r; v.ready = rd; v.redir = rdir; v.rpc = rpc; v.expValid = ev; v.expPc = epc;
      vecs.push_back(v);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic modelReset();
      mState = M_IDLE;
      mPc = RPC;
      mInflight = 0;
      mIpc = 32'd0;
      mq.delete();
   endtask

   // One rising edge of the specified behaviour, using the inputs currently driven
   task automatic modelStep();
      int occ;
      bit xfer;
      xfer = (mq.size() != 0) && instReady;
      occ = int'(mq.size()) + int'(mInflight) - int'(xfer);
      if (xfer) void'(mq.pop_front());
      if (redirect) begin
         mq.delete();
         mInflight = 0;
         if (mState != M_HALT) begin
            mPc = redirectPc;
            if (redirectPc >= 32'(DEPTH)) mState = M_HALT;
            else mState = run ? M_FETCH : M_IDLE;
         end
      end else begin
         if (mInflight) mq.push_back(mIpc);
         mInflight = 0;
         if (mState != M_HALT) begin
            if (run && occ < CAP && mPc >= 32'(DEPTH)) begin
               mState = M_HALT;
            end else begin
               if (run && occ < CAP) begin
                  mInflight = 1;
                  mIpc = mPc;
                  mPc = mPc + 32'd1;
               end
               mState = run ? M_FETCH : M_IDLE;
            end
         end
      end
   endtask

   task automatic compareModel();
      checkOutput("inst_valid", 32'(instValid), 32'(mq.size() != 0));
      checkOutput("halted", 32'(halted), 32'(mState == M_HALT));
      checkOutput("rom_addr", romAddr, mPc);
      if (mq.size() != 0) begin
         checkOutput("inst_pc", instPc, mq[0]);
         checkOutput("inst_out", instOut, romWord(mq[0]));
      end
   endtask

   // Called at a falling edge: drive, clock once, compare against the model
   task automatic applyStimulus(input logic r, input logic rd, input logic rdir, input logic [31:0] rpc);
      run = r; instReady = rd; redirect = rdir; redirectPc = rpc;
      if (instValid && instReady) dutAcc.push_back(instPc);
      @(posedge clock);
      modelStep();
      @(negedge clock);
      compareModel();
   endtask

   task automatic doReset();
      run = 0; redirect = 0; instReady = 0; redirectPc = 32'd0;
      #2;
      reset = 1;
      modelReset();
      #1;
      checkOutput("rst_valid", 32'(instValid), 32'd0);
      checkOutput("rst_pc", instPc, 32'd0);
      checkOutput("rst_out", instOut, 32'd0);
      checkOutput("rst_halted", 32'(halted), 32'd0);
      checkOutput("rst_rom_addr", romAddr, RPC);
      @(posedge clock);
      @(negedge clock);
      reset = 0;
   endtask

   initial begin
      int bad;
      bit done;
      reset = 1; run = 0; instReady = 0; redirect = 0; redirectPc = 32'd0;
      doReset();

      // Streaming from reset, then a redirect on the edge that accepts pc 3
`ifdef FETCH_CTRL_QUEUE2_EN
      addVec(1, 1, 0, 0, 0, 0);
      addVec(1, 1, 0, 0, 1, 0);
      addVec(1, 1, 0, 0, 1, 1);
      addVec(1, 1, 0, 0, 1, 2);
      addVec(1, 1, 0, 0, 1, 3);
      addVec(1, 1, 1, 8, 0, 0);
      addVec(1, 1, 0, 0, 0, 0);
      addVec(1, 1, 0, 0, 1, 8);
      addVec(1, 1, 0, 0, 1, 9);
`else
      addVec(1, 1, 0, 0, 0, 0);
      addVec(1, 1, 0, 0, 1, 0);
      addVec(1, 1, 0, 0, 0, 0);
      addVec(1, 1, 0, 0, 1, 1);
      addVec(1, 1, 0, 0, 0, 0);
      addVec(1, 1, 0, 0, 1, 2);
      addVec(1, 1, 0, 0, 0, 0);
      addVec(1, 1, 0, 0, 1, 3);
      addVec(1, 1, 1, 8, 0, 0);
      addVec(1, 1, 0, 0, 0, 0);
      addVec(1, 1, 0, 0, 1, 8);
      addVec(1, 1, 0, 0, 0, 0);
      addVec(1, 1, 0, 0, 1, 9);
`endif
      dutAcc.delete();
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].run, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
         checkOutput($sformatf("tbl%0d_valid", i), 32'(instValid), 32'(vecs[i].expValid));
         if (vecs[i].expValid) begin
            checkOutput($sformatf("tbl%0d_pc", i), instPc, vecs[i].expPc);
            checkOutput($sformatf("tbl%0d_out", i), instOut, romWord(vecs[i].expPc));
         end
      end
      bad = 0;
      foreach (dutAcc[i]) if (dutAcc[i] == 32'd4 || dutAcc[i] == 32'd5) bad++;
      checkOutput("no_pc4_5", 32'(bad), 32'd0);

      // Reset while a word is presented, then restart from RESET_PC
      done = 0;
      for (int i = 0; i < 6 && !done; i++) begin
         applyStimulus(1, 0, 0, 0);
         done = instValid;
      end
      checkOutput("pre_reset_valid", 32'(instValid), 32'd1);
      doReset();
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 1, 0, 0);
      checkOutput("restart_valid", 32'(instValid), 32'd1);
      checkOutput("restart_pc", instPc, RPC);

      // Backpressure with a full queue, then release
      doReset();
      for (int i = 0; i < CAP + 1; i++) applyStimulus(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 0, 0, 0);
         checkOutput("stall_pc", instPc, 32'd0);
         checkOutput("stall_out", instOut, romWord(32'd0));
         checkOutput("stall_rom_addr", romAddr, 32'(CAP));
      end
      dutAcc.delete();
      for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 0);
      checkOutput("release_count_ok", 32'(dutAcc.size() >= 4), 32'd1);
      foreach (dutAcc[i]) checkOutput($sformatf("release_seq%0d", i), dutAcc[i], 32'(i));

      // Running off the end of the ROM
      doReset();
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 1, 1, 32'(DEPTH - 4));
      dutAcc.delete();
      done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         applyStimulus(1, 1, 0, 0);
         done = halted && !instValid;
      end
      checkOutput("end_halted", 32'(halted), 32'd1);
      checkOutput("end_count", 32'(dutAcc.size()), 32'd4);
      foreach (dutAcc[i]) checkOutput($sformatf("end_pc%0d", i), dutAcc[i], 32'(DEPTH - 4 + i));
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 0, 0);
         checkOutput("halt_rom_addr", romAddr, 32'(DEPTH));
         checkOutput("halt_valid", 32'(instValid), 32'd0);
      end

      // Redirect to an out-of-range target halts on that edge
      doReset();
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 1, 1, 32'd1024);
      checkOutput("redir_halt", 32'(halted), 32'd1);

      // Random traffic against the model
      doReset();
      for (int i = 0; i < 800; i++) begin
         if ((halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
            doReset();
         end else begin
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 15) == 0, 32'($urandom_range(0, DEPTH + 6)));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
